reg_dump_reader: RTL and testbench

- Debug/trace block that walks a contiguous range of architectural registers through one read port of the core register file.
- Streams each value out over a valid/ready interface as an (index, data) beat.
- Sits beside the register file on a spare read port (A-port address, RD data); it never writes the file.
- Used by the bench and the debug path to snapshot x-register state after a program runs.

---
 rtl/reg_dump_reader_pkg.sv | 18 +
 rtl/reg_dump_reader.sv | 129 ++++++++++++
 tb/tb_reg_dump_reader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_reader_pkg.sv
// rtl/reg_dump_reader_pkg.sv - shared types and constants for the register dump reader
package reg_dump_reader_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_REGS_DEF = 2 ** ADDR_W_DEF;

    // x0 is hardwired to zero architecturally, whatever the file array holds.
    localparam int X0_IDX = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - walks a register index range through a spare read port and streams (index, data) beats
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   start                   one-cycle dump request, honoured only in IDLE
//   first_idx, last_idx     inclusive register range to dump
//   abort                   cancels a dump in READ/SEND, no done pulse
//   rd_addr, rd_data        register file read port (combinational read data)
//   out_valid, out_ready    beat handshake
//   out_idx, out_data       register index and value of the current beat
//   busy                    high in READ and SEND
//   done                    one-cycle pulse when the range completes normally
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_idx,
    input  logic [ADDR_W-1:0] last_idx,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] X0       = ADDR_W'(X0_IDX);

    state_t            state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] lim;

    // A file smaller than the index space must never be addressed past its top.
    logic [ADDR_W-1:0] last_clamped;
    assign last_clamped = (last_idx > LAST_REG) ? LAST_REG : last_idx;

    logic accept;
    assign accept = out_valid && out_ready;

    // The only unregistered output: the file sees the address only while reading.
    assign rd_addr = (state == ST_READ) ? cur : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cur       <= '0;
            lim       <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cur <= first_idx;
                        lim <= last_clamped;
                        if (first_idx <= last_clamped) begin
                            state <= ST_READ;
                            busy  <= 1'b1;
                        end else begin
                            // Empty range: complete immediately with no beats.
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                ST_READ: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        out_data  <= (cur == X0) ? '0 : rd_data;
                        out_idx   <= cur;
                        out_valid <= 1'b1;
                        state     <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    // abort wins over a beat accepted on the same edge.
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (accept) begin
                        out_valid <= 1'b0;
                        // Stop on lim before incrementing so last_idx at the
                        // top of the index space never wraps cur.
                        if (cur == lim) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            cur   <= cur + 1'b1;
                            state <= ST_READ;
                        end
                    end
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb/tb_reg_dump_reader.sv - randomized self-checking bench for reg_dump_reader
module tb_reg_dump_reader;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] first_idx;
    logic [AW-1:0] last_idx;
    logic          abort;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_idx;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    logic [DW-1:0] rf [NR];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rd_data = rf[rd_addr];

    reg_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .abort     (abort),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low until the
    // beat has been visible for 5 cycles. abort_idx >= 0 aborts when that
    // index is presented. repulse fires a second start mid-dump.
    task automatic dump(input logic [AW-1:0] f, input logic [AW-1:0] l, input int mode,
                        input int abort_idx, input bit repulse);
        logic [AW-1:0] exp_idx[$];
        logic [DW-1:0] exp_dat[$];
        logic [AW-1:0] h_idx;
        logic [DW-1:0] h_dat;
        int  n, beats, done_cnt, done_at, nexp, valid_seen, tail;
        bit  aborted, post_abort, prev_hold;

        // Reference: every index of the inclusive range in order, x0 reads zero,
        // truncated before the aborted index.
        if (f <= l) begin
            for (int i = int'(f); i <= int'(l); i++) begin
                if (abort_idx >= 0 && i >= abort_idx) break;
                exp_idx.push_back(AW'(i));
                exp_dat.push_back((i == 0) ? '0 : rf[i[AW-1:0]]);
            end
        end
        nexp = exp_idx.size();
        beats = 0; done_cnt = 0; done_at = -1; valid_seen = 0; tail = -1;
        aborted = 0; post_abort = 0; prev_hold = 0;
        h_idx = '0; h_dat = '0;

        first_idx = f;
        last_idx  = l;
        start     = 1'b1;
        out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;

        while (n < 400 && tail != 0) begin
            @(negedge clk);
            if (post_abort) begin
                check("abort_valid_drop", 64'(out_valid), 64'(0));
                check("abort_busy_drop", 64'(busy), 64'(0));
                post_abort = 0;
            end
            if (prev_hold) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_idx", 64'(out_idx), 64'(h_idx));
                check("hold_data", 64'(out_data), 64'(h_dat));
                prev_hold = 0;
            end
            if (nexp == 0 && abort_idx < 0) begin
                check("empty_busy", 64'(busy), 64'(0));
                check("empty_valid", 64'(out_valid), 64'(0));
            end
            if (done) begin
                done_cnt++;
                done_at = n;
            end
            if (out_valid && !aborted) begin
                valid_seen++;
                if (abort_idx >= 0 && int'(out_idx) == abort_idx) begin
                    abort      = 1'b1;
                    out_ready  = 1'b1;
                    aborted    = 1;
                    post_abort = 1;
                    tail       = 3;
                end else if (out_ready) begin
                    if (exp_idx.size() == 0) begin
                        check("beat_overrun", 64'(beats + 1), 64'(nexp));
                    end else begin
                        check("beat_idx", 64'(out_idx), 64'(exp_idx.pop_front()));
                        check("beat_data", 64'(out_data), 64'(exp_dat.pop_front()));
                    end
                    beats++;
                end else begin
                    prev_hold = 1;
                    h_idx = out_idx;
                    h_dat = out_data;
                end
            end
            if (done && tail < 0) tail = 2;
            if (tail > 0) tail--;
            @(posedge clk);
            #1;
            n++;
            abort = 1'b0;
            if (repulse && n == 3) begin
                start = 1'b1; first_idx = '0; last_idx = '1;
            end else begin
                start = 1'b0;
            end
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (valid_seen >= 5);
        end

        check("no_timeout", 64'(n < 400), 64'(1));
        check("beat_count", 64'(beats), 64'(nexp));
        check("done_count", 64'(done_cnt), 64'(aborted ? 0 : 1));
        if (mode == 0 && abort_idx < 0)
            check("done_latency", 64'(done_at), 64'(2 * nexp + 1));
    endtask

    initial begin
        logic [AW-1:0] rf_f, rf_l;
        int ab;

        reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        first_idx = '0; last_idx = '0;
        for (int i = 0; i < NR; i++) rf[i] = $urandom;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_idx", 64'(out_idx), 64'(0));
        check("rst_data", 64'(out_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_rd_addr", 64'(rd_addr), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        rf[2] = 32'h2; rf[4] = 32'h1c; rf[5] = 32'h6;
        rf[6] = 32'hA; rf[8] = 32'h10; rf[9] = 32'hf4;
        dump(5'd2, 5'd9, 0, -1, 0);

        rf[0] = 32'hDEADBEEF;
        dump(5'd0, 5'd1, 0, -1, 0);

        dump(5'd4, 5'd4, 2, -1, 0);

        dump(5'd9, 5'd2, 0, -1, 0);

        dump(5'd2, 5'd9, 0, 5, 0);
        dump(5'd8, 5'd9, 0, -1, 0);

        // Reset in the middle of a stalled beat clears outputs without a clock.
        first_idx = 5'd2; last_idx = 5'd9; start = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_reset_valid", 64'(out_valid), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'(0));
        check("async_rst_busy", 64'(busy), 64'(0));
        check("async_rst_data", 64'(out_data), 64'(0));
        check("async_rst_done", 64'(done), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        dump(5'd2, 5'd5, 0, -1, 1);

        dump(5'd28, 5'd31, 0, -1, 0);
        dump(5'd31, 5'd31, 1, -1, 0);
        dump(5'd0, 5'd31, 0, -1, 0);

        repeat (12) begin
            for (int i = 0; i < NR; i++) rf[i] = $urandom;
            rf_f = AW'($urandom_range(0, NR - 1));
            rf_l = AW'($urandom_range(0, NR - 1));
            ab = -1;
            if (rf_f <= rf_l && $urandom_range(0, 3) == 0)
                ab = int'($urandom_range(int'(rf_f), int'(rf_l)));
            dump(rf_f, rf_l, 1, ab, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
